// File: rtl/avl_map_sprite_regs.sv
// Avalon-MM slave feeding the tile-map renderer: map writes are queued in a
// show-ahead FIFO, and double-buffered sprite X/Y registers commit at frame start.
module avl_map_sprite_regs #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 9,
  parameter int NUM_SPRITES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          AVL_CS,
  input  logic                          AVL_READ,
  input  logic                          AVL_WRITE,
  input  logic [ADDR_W-1:0]             AVL_ADDR,
  input  logic [DATA_W-1:0]             AVL_WRITEDATA,
  output logic [DATA_W-1:0]             AVL_READDATA,
  output logic                          AVL_WAITREQUEST,
  input  logic                          MAP_WRITE_READY,
  output logic                          MAP_WRITE_ENABLE,
  output logic [ADDR_W-2:0]             MAP_WRITE_ADDR,
  output logic [DATA_W-1:0]             MAP_WRITE_DATA,
  input  logic                          FRAME_START,
  output logic [NUM_SPRITES*DATA_W-1:0] SPRITE_X,
  output logic [NUM_SPRITES*DATA_W-1:0] SPRITE_Y,
  output logic                          COMMIT_PENDING
);

  localparam int IDX_W   = ADDR_W - 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = IDX_W + DATA_W;

  logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic [DATA_W-1:0]  shadow_x_r [NUM_SPRITES];
  logic [DATA_W-1:0]  shadow_y_r [NUM_SPRITES];
  logic [DATA_W-1:0]  live_x_r   [NUM_SPRITES];
  logic [DATA_W-1:0]  live_y_r   [NUM_SPRITES];
  logic               pending_r;
  logic [DATA_W-1:0]  readdata_r;

  logic               region_s;
  logic [IDX_W-1:0]   idx_s;
  logic               empty_s;
  logic               full_s;
  logic               wr_acc_s;
  logic               push_s;
  logic               pop_s;
  logic               reg_wr_s;
  logic               ctrl_arm_s;
  logic               commit_s;
  logic [DATA_W-1:0]  status_s;
  logic [DATA_W-1:0]  reg_rdata_s;
  logic [DATA_W-1:0]  rd_mux_s;

  assign region_s  = AVL_ADDR[ADDR_W-1];
  assign idx_s     = AVL_ADDR[IDX_W-1:0];
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));

  // The stall looks only at the current fill level, so a pop in the same
  // cycle never lets a write slip into a full FIFO.
  assign AVL_WAITREQUEST = AVL_CS & AVL_WRITE & ~region_s & full_s;
  assign wr_acc_s        = AVL_CS & AVL_WRITE & ~AVL_WAITREQUEST;
  assign push_s          = wr_acc_s & ~region_s;
  assign pop_s           = ~empty_s & MAP_WRITE_READY;
  assign reg_wr_s        = wr_acc_s & region_s;
  assign ctrl_arm_s      = reg_wr_s & (idx_s == IDX_W'(2*NUM_SPRITES+1)) & AVL_WRITEDATA[0];
  assign commit_s        = FRAME_START & pending_r;

  assign MAP_WRITE_ENABLE = pop_s;
  assign MAP_WRITE_ADDR   = fifo_mem_r[rd_ptr_r][ENTRY_W-1:DATA_W];
  assign MAP_WRITE_DATA   = fifo_mem_r[rd_ptr_r][DATA_W-1:0];
  assign AVL_READDATA     = readdata_r;
  assign COMMIT_PENDING   = pending_r;
  assign status_s         = {{(DATA_W-3){1'b0}}, full_s, empty_s, pending_r};

  // FIFO storage; stale entries are harmless because the count gates the head.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {idx_s, AVL_WRITEDATA};
    end
  end

  // FIFO pointers and fill count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Shadow registers take bus writes; live registers copy the pre-write shadow on commit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_x_r[i] <= {DATA_W{1'b0}};
        shadow_y_r[i] <= {DATA_W{1'b0}};
        live_x_r[i]   <= {DATA_W{1'b0}};
        live_y_r[i]   <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (reg_wr_s && (idx_s == IDX_W'(2*i))) begin
          shadow_x_r[i] <= AVL_WRITEDATA;
        end
        if (reg_wr_s && (idx_s == IDX_W'(2*i+1))) begin
          shadow_y_r[i] <= AVL_WRITEDATA;
        end
        if (commit_s) begin
          live_x_r[i] <= shadow_x_r[i];
          live_y_r[i] <= shadow_y_r[i];
        end
      end
    end
  end

  // Commit arm flag; a fresh arm wins over a same-edge clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_r <= 1'b0;
    end else if (ctrl_arm_s) begin
      pending_r <= 1'b1;
    end else if (commit_s) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Register-region read decode as an AND-OR mux.
  always_comb begin
    reg_rdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      reg_rdata_s = reg_rdata_s
                  | ({DATA_W{idx_s == IDX_W'(2*i)}}   & shadow_x_r[i])
                  | ({DATA_W{idx_s == IDX_W'(2*i+1)}} & shadow_y_r[i]);
    end
    reg_rdata_s = reg_rdata_s | ({DATA_W{idx_s == IDX_W'(2*NUM_SPRITES)}} & status_s);
  end

  assign rd_mux_s = region_s ? reg_rdata_s : {DATA_W{1'b0}};

  // Read data register: one-cycle latency, held until the next read.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      readdata_r <= {DATA_W{1'b0}};
    end else if (AVL_CS && AVL_READ) begin
      readdata_r <= rd_mux_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign SPRITE_X[g*DATA_W +: DATA_W] = live_x_r[g];
    assign SPRITE_Y[g*DATA_W +: DATA_W] = live_y_r[g];
  end

endmodule

// File: tb/tb_avl_map_sprite_regs.sv
// Directed self-checking bench for avl_map_sprite_regs with default parameters.
module tb_avl_map_sprite_regs;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [8:0]  AVL_ADDR;
  logic [7:0]  AVL_WRITEDATA;
  logic [7:0]  AVL_READDATA;
  logic        AVL_WAITREQUEST;
  logic        MAP_WRITE_READY;
  logic        MAP_WRITE_ENABLE;
  logic [7:0]  MAP_WRITE_ADDR;
  logic [7:0]  MAP_WRITE_DATA;
  logic        FRAME_START;
  logic [31:0] SPRITE_X;
  logic [31:0] SPRITE_Y;
  logic        COMMIT_PENDING;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rd;

  avl_map_sprite_regs #(.DATA_W(8), .ADDR_W(9), .NUM_SPRITES(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AVL_WAITREQUEST(AVL_WAITREQUEST), .MAP_WRITE_READY(MAP_WRITE_READY),
    .MAP_WRITE_ENABLE(MAP_WRITE_ENABLE), .MAP_WRITE_ADDR(MAP_WRITE_ADDR),
    .MAP_WRITE_DATA(MAP_WRITE_DATA), .FRAME_START(FRAME_START), .SPRITE_X(SPRITE_X),
    .SPRITE_Y(SPRITE_Y), .COMMIT_PENDING(COMMIT_PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic avl_write(input logic [8:0] a, input logic [7:0] d);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic avl_read(input logic [8:0] a, output logic [7:0] d);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    tick();
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  initial begin
    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = 9'h000; AVL_WRITEDATA = 8'h00; MAP_WRITE_READY = 1'b0; FRAME_START = 1'b0;
    tick(); tick();
    RESET = 1'b0;

    // Reset state
    check("rst_men", {31'd0, MAP_WRITE_ENABLE}, 32'd0);
    check("rst_wait", {31'd0, AVL_WAITREQUEST}, 32'd0);
    check("rst_rdata", {24'd0, AVL_READDATA}, 32'd0);
    check("rst_sx", SPRITE_X, 32'd0);
    check("rst_sy", SPRITE_Y, 32'd0);
    check("rst_pend", {31'd0, COMMIT_PENDING}, 32'd0);
    avl_read(9'h108, rd);
    check("rst_status", {24'd0, rd}, 32'h02);

    // Single map write drains one cycle later for exactly one cycle
    MAP_WRITE_READY = 1'b1;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 9'h005; AVL_WRITEDATA = 8'hAA;
    #1;
    check("single_pre_men", {31'd0, MAP_WRITE_ENABLE}, 32'd0);
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    check("single_men", {31'd0, MAP_WRITE_ENABLE}, 32'd1);
    check("single_head", {16'd0, MAP_WRITE_ADDR, MAP_WRITE_DATA}, 32'h05AA);
    tick();
    check("single_men_off", {31'd0, MAP_WRITE_ENABLE}, 32'd0);

    // Fill FIFO with READY low, fifth write stalls
    MAP_WRITE_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      avl_write(9'h010 + 9'(i), 8'h01 + 8'(i));
    end
    check("full_men", {31'd0, MAP_WRITE_ENABLE}, 32'd0);
    avl_read(9'h108, rd);
    check("full_status", {24'd0, rd}, 32'h04);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 9'h014; AVL_WRITEDATA = 8'h05;
    #1;
    check("full_wait0", {31'd0, AVL_WAITREQUEST}, 32'd1);
    tick();
    check("full_wait1", {31'd0, AVL_WAITREQUEST}, 32'd1);
    MAP_WRITE_READY = 1'b1;
    #1;
    check("full_wait_pop", {31'd0, AVL_WAITREQUEST}, 32'd1);
    check("drain_1", {15'd0, MAP_WRITE_ENABLE, MAP_WRITE_ADDR, MAP_WRITE_DATA}, 32'h11001);
    tick();
    check("wait_release", {31'd0, AVL_WAITREQUEST}, 32'd0);
    check("drain_2", {15'd0, MAP_WRITE_ENABLE, MAP_WRITE_ADDR, MAP_WRITE_DATA}, 32'h11102);
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    check("drain_3", {15'd0, MAP_WRITE_ENABLE, MAP_WRITE_ADDR, MAP_WRITE_DATA}, 32'h11203);
    tick();
    check("drain_4", {15'd0, MAP_WRITE_ENABLE, MAP_WRITE_ADDR, MAP_WRITE_DATA}, 32'h11304);
    tick();
    check("drain_5", {15'd0, MAP_WRITE_ENABLE, MAP_WRITE_ADDR, MAP_WRITE_DATA}, 32'h11405);
    tick();
    check("drain_done", {31'd0, MAP_WRITE_ENABLE}, 32'd0);
    avl_read(9'h108, rd);
    check("drained_status", {24'd0, rd}, 32'h02);

    // Shadow writes do not touch live registers until committed
    avl_write(9'h100, 8'h30);
    avl_write(9'h101, 8'h40);
    check("shadow_sx", SPRITE_X, 32'd0);
    check("shadow_sy", SPRITE_Y, 32'd0);
    avl_read(9'h100, rd);
    check("shadow_rd_x0", {24'd0, rd}, 32'h30);
    avl_read(9'h101, rd);
    check("shadow_rd_y0", {24'd0, rd}, 32'h40);
    avl_write(9'h109, 8'h01);
    check("arm_pend", {31'd0, COMMIT_PENDING}, 32'd1);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    check("commit_sx", SPRITE_X, 32'h30);
    check("commit_sy", SPRITE_Y, 32'h40);
    check("commit_pend", {31'd0, COMMIT_PENDING}, 32'd0);

    // FRAME_START without pending changes nothing
    avl_write(9'h102, 8'h77);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    check("nopend_sx", SPRITE_X, 32'h30);

    // Arm on the FRAME_START edge defers the commit
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 9'h109; AVL_WRITEDATA = 8'h01; FRAME_START = 1'b1;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; FRAME_START = 1'b0;
    check("samecyc_pend", {31'd0, COMMIT_PENDING}, 32'd1);
    check("samecyc_sx", SPRITE_X, 32'h30);
    avl_read(9'h108, rd);
    check("pend_status", {24'd0, rd}, 32'h03);
    avl_write(9'h109, 8'h00);
    check("ctrl_zero_pend", {31'd0, COMMIT_PENDING}, 32'd1);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    check("deferred_sx", SPRITE_X, 32'h7730);
    check("deferred_pend", {31'd0, COMMIT_PENDING}, 32'd0);

    // Shadow write on the commit edge is excluded from the commit
    avl_write(9'h101, 8'h41);
    avl_write(9'h109, 8'h01);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 9'h100; AVL_WRITEDATA = 8'h55; FRAME_START = 1'b1;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; FRAME_START = 1'b0;
    check("edge_sx", SPRITE_X, 32'h7730);
    check("edge_sy", SPRITE_Y, 32'h41);
    avl_read(9'h109, rd);
    check("ctrl_rd", {24'd0, rd}, 32'h00);
    avl_read(9'h10A, rd);
    check("unused_rd", {24'd0, rd}, 32'h00);
    avl_read(9'h005, rd);
    check("map_rd", {24'd0, rd}, 32'h00);
    avl_read(9'h100, rd);
    check("edge_shadow_x0", {24'd0, rd}, 32'h55);
    tick();
    check("rdata_hold", {24'd0, AVL_READDATA}, 32'h55);

    // Reset in the middle of a drain
    MAP_WRITE_READY = 1'b0;
    avl_write(9'h020, 8'hA0);
    avl_write(9'h021, 8'hA1);
    avl_write(9'h022, 8'hA2);
    MAP_WRITE_READY = 1'b1;
    #1;
    check("predrain_head", {15'd0, MAP_WRITE_ENABLE, MAP_WRITE_ADDR, MAP_WRITE_DATA}, 32'h120A0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midrst_men", {31'd0, MAP_WRITE_ENABLE}, 32'd0);
    check("midrst_sx", SPRITE_X, 32'd0);
    check("midrst_sy", SPRITE_Y, 32'd0);
    check("midrst_rdata", {24'd0, AVL_READDATA}, 32'd0);
    tick();
    check("midrst_men2", {31'd0, MAP_WRITE_ENABLE}, 32'd0);
    avl_read(9'h108, rd);
    check("midrst_status", {24'd0, rd}, 32'h02);
    avl_read(9'h100, rd);
    check("midrst_shadow", {24'd0, rd}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_map_sprite_regs.md
Name: avl_map_sprite_regs

Overview:
Parametrised Avalon-MM slave between the HPS/NIOS bus and the tile-map renderer. The low half of the address space buffers map-RAM writes in a FIFO, and the FIFO drains only when the renderer grants the map port. The high half holds double-buffered per-sprite X/Y position registers, which commit atomically at frame start, plus status/control registers with read-back.

Parameters:
DATA_W, 8, data width of bus, map data and sprite coordinates
ADDR_W, 9, Avalon address width; bit ADDR_W-1 selects region (0 = map, 1 = registers)
NUM_SPRITES, 4, number of sprite X/Y register pairs; 2*NUM_SPRITES+2 <= 2**(ADDR_W-1)
FIFO_DEPTH, 4, map write FIFO entries, power of two >= 2

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous active-high reset
AVL_CS  in  1  chip select
AVL_READ  in  1  read strobe
AVL_WRITE  in  1  write strobe
AVL_ADDR  in  ADDR_W  word address
AVL_WRITEDATA  in  DATA_W  write data
AVL_READDATA  out  DATA_W  read data, fixed read latency 1
AVL_WAITREQUEST  out  1  stalls map-region writes while FIFO is full
MAP_WRITE_READY  in  1  renderer grants map port this cycle
MAP_WRITE_ENABLE  out  1  map write strobe
MAP_WRITE_ADDR  out  ADDR_W-1  map address (FIFO head)
MAP_WRITE_DATA  out  DATA_W  map data (FIFO head)
FRAME_START  in  1  one-cycle pulse at start of vertical blank
SPRITE_X  out  NUM_SPRITES*DATA_W  live X positions; sprite i at bits [i*DATA_W +: DATA_W]
SPRITE_Y  out  NUM_SPRITES*DATA_W  live Y positions, same packing
COMMIT_PENDING  out  1  commit armed, waiting for FRAME_START

Behaviour:
- One clock, CLK. RESET is synchronous and active-high, sampled on the rising edge of CLK.
- Reset: FIFO emptied (in-flight entries discarded), shadow and live sprite registers = 0, COMMIT_PENDING = 0, AVL_READDATA = 0. AVL_WAITREQUEST = 0 and MAP_WRITE_ENABLE = 0 as a consequence of the empty FIFO.
- Accepted write: AVL_CS & AVL_WRITE & !AVL_WAITREQUEST.
- Map region (AVL_ADDR[ADDR_W-1] = 0):
  - An accepted write pushes {AVL_ADDR[ADDR_W-2:0], AVL_WRITEDATA}.
  - AVL_WAITREQUEST = AVL_CS & AVL_WRITE & region 0 & full. It is combinational and ignores a same-cycle pop, so there is no push when full.
- FIFO drain is show-ahead:
  - MAP_WRITE_ADDR/DATA = head entry; MAP_WRITE_ENABLE = !empty & MAP_WRITE_READY; the pop occurs at the same edge.
  - An entry pushed at edge N is eligible from cycle N+1.
  - Writes drain strictly in order; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - While empty, MAP_WRITE_ADDR/DATA are don't-care and MAP_WRITE_ENABLE = 0.
- Register region (AVL_ADDR[ADDR_W-1] = 1); index r = AVL_ADDR[ADDR_W-2:0]:
  - r = 2i: shadow X of sprite i, read/write.
  - r = 2i+1: shadow Y of sprite i, read/write.
  - r = 2*NUM_SPRITES: STATUS, read-only; bit0 COMMIT_PENDING, bit1 FIFO empty, bit2 FIFO full, other bits 0.
  - r = 2*NUM_SPRITES+1: CTRL, write-only. Writing bit0 = 1 sets pending; writing bit0 = 0 leaves it unchanged. Reads return 0.
  - Other indices: reads return 0, writes are ignored.
  - Register writes never stall.
- Read:
  - AVL_CS & AVL_READ at edge N → AVL_READDATA valid after edge N, i.e. in cycle N+1.
  - Map-region reads return 0.
  - AVL_READDATA holds its value until the next read.
- Commit:
  - On an edge with FRAME_START & pending: live X/Y ← shadow X/Y for all sprites, and pending is cleared.
  - A shadow write at the same edge is not included; live receives the pre-write shadow.
  - A CTRL arm at the same edge as FRAME_START does not commit; pending is 1 afterwards and the commit occurs at the next FRAME_START.
  - FRAME_START without pending: no change.
- Reset mid-drain: FIFO contents are lost and MAP_WRITE_ENABLE = 0 from the next cycle.

Test Plan:
- Reset, then write map addr 0x05 data 0xAA with MAP_WRITE_READY = 1 → MAP_WRITE_ENABLE = 1 one cycle later with addr 0x05 / data 0xAA, for exactly one cycle.
- MAP_WRITE_READY = 0, write map data 0x01..0x05 (addresses 0x10..0x14), FIFO_DEPTH = 4 → 5th write sees AVL_WAITREQUEST = 1 until READY = 1. Drain order is 0x01..0x05; STATUS reads 0x04 when full, 0x02 after drain.
- Write 0x100 (X0) = 0x30, 0x101 (Y0) = 0x40 → SPRITE_X/Y[0] stay 0 and read-back of 0x100 returns 0x30. Write CTRL 0x109 = 0x01, pulse FRAME_START → SPRITE_X[7:0] = 0x30, SPRITE_Y[7:0] = 0x40, COMMIT_PENDING = 0.
- CTRL arm and FRAME_START in the same cycle → no commit, COMMIT_PENDING = 1; the next FRAME_START commits.
- With X0 shadow = 0x30 armed, write X0 = 0x55 on the FRAME_START edge → live X0 = 0x30, shadow reads 0x55.
- FIFO holding 3 entries with READY = 1, assert RESET for one cycle → MAP_WRITE_ENABLE = 0, STATUS = 0x02, sprites = 0.
